// File: rtl/pipeline_stall_controller.sv
// Turns hazard-detector requests into pipeline register enables, bubbles and
// flushes, sequencing multi-cycle stalls and keeping saturating perf counters.
module pipeline_stall_controller #(
   parameter int unsigned BR_LD_STALLS = 2,
   parameter int unsigned CNT_W        = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_load_use,
   input  logic             i_br_stall,
   input  logic             i_br_ld_stall,
   input  logic             i_br_taken,
   input  logic             i_mem_busy,
   output logic             o_pc_en,
   output logic             o_if_id_en,
   output logic             o_id_ex_en,
   output logic             o_ex_mem_en,
   output logic             o_mem_wb_en,
   output logic             o_if_id_flush,
   output logic             o_id_ex_bubble,
   output logic [CNT_W-1:0] o_stall_cnt,
   output logic [CNT_W-1:0] o_flush_cnt
);

   localparam int unsigned HC_W = 2;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      HOLD     = 2'd1,
      MEM_WAIT = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [HC_W-1:0]   hold_q, hold_d;
   logic [CNT_W-1:0]  stall_cnt_q, flush_cnt_q;
   logic              act_hold;

   // State, hold counter and performance counters
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= RUN;
         hold_q      <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         if (!o_pc_en && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         if (o_if_id_flush && (flush_cnt_q != {CNT_W{1'b1}}))
            flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
   end

   // Next state and stage controls
   always_comb begin
      state_d        = state_q;
      hold_d         = hold_q;
      act_hold       = 1'b0;
      o_pc_en        = 1'b1;
      o_if_id_en     = 1'b1;
      o_id_ex_en     = 1'b1;
      o_ex_mem_en    = 1'b1;
      o_mem_wb_en    = 1'b1;
      o_if_id_flush  = 1'b0;
      o_id_ex_bubble = 1'b0;

      // A non-zero hold count in MEM_WAIT means the freeze interrupted HOLD
      unique case (state_q)
         HOLD:     act_hold = 1'b1;
         MEM_WAIT: act_hold = (hold_q != '0);
         default:  act_hold = 1'b0;
      endcase

      if (i_mem_busy) begin
         o_pc_en     = 1'b0;
         o_if_id_en  = 1'b0;
         o_id_ex_en  = 1'b0;
         o_ex_mem_en = 1'b0;
         o_mem_wb_en = 1'b0;
         state_d     = MEM_WAIT;
      end else if (act_hold) begin
         o_pc_en        = 1'b0;
         o_if_id_en     = 1'b0;
         o_id_ex_bubble = 1'b1;
         if (hold_q <= HC_W'(1)) begin
            hold_d  = '0;
            state_d = RUN;
         end else begin
            hold_d  = hold_q - HC_W'(1);
            state_d = HOLD;
         end
      end else if (i_br_ld_stall) begin
         o_pc_en        = 1'b0;
         o_if_id_en     = 1'b0;
         o_id_ex_bubble = 1'b1;
         hold_d         = HC_W'(BR_LD_STALLS - 1);
         state_d        = (BR_LD_STALLS > 1) ? HOLD : RUN;
      end else if (i_load_use || i_br_stall) begin
         o_pc_en        = 1'b0;
         o_if_id_en     = 1'b0;
         o_id_ex_bubble = 1'b1;
         state_d        = RUN;
      end else begin
         o_if_id_flush = i_br_taken;
         state_d       = RUN;
      end

      if (i_rst) begin
         o_pc_en        = 1'b0;
         o_if_id_en     = 1'b0;
         o_id_ex_en     = 1'b0;
         o_ex_mem_en    = 1'b0;
         o_mem_wb_en    = 1'b0;
         o_if_id_flush  = 1'b1;
         o_id_ex_bubble = 1'b1;
      end
   end

   assign o_stall_cnt = stall_cnt_q;
   assign o_flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller: three instances cover
// BR_LD_STALLS=2/3/1, the last with 2-bit counters for saturation.
module tb_pipeline_stall_controller;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic lu = 1'b0, bs = 1'b0, bl = 1'b0, bt = 1'b0, mb = 1'b0;

   always #5 clk = ~clk;

   // Control pattern order: pc, if_id, id_ex, ex_mem, mem_wb, flush, bubble
   localparam logic [6:0] P_RUN    = 7'b11111_00;
   localparam logic [6:0] P_FREEZE = 7'b00000_00;
   localparam logic [6:0] P_STALL  = 7'b00111_01;
   localparam logic [6:0] P_FLUSH  = 7'b11111_10;
   localparam logic [6:0] P_RST    = 7'b00000_11;

   logic        a_pc, a_ifid, a_idex, a_exmem, a_memwb, a_fl, a_bb;
   logic        b_pc, b_ifid, b_idex, b_exmem, b_memwb, b_fl, b_bb;
   logic        c_pc, c_ifid, c_idex, c_exmem, c_memwb, c_fl, c_bb;
   logic [15:0] a_scnt, a_fcnt, b_scnt, b_fcnt;
   logic [1:0]  c_scnt, c_fcnt;
   logic [6:0]  pa, pb, pc;

   assign pa = {a_pc, a_ifid, a_idex, a_exmem, a_memwb, a_fl, a_bb};
   assign pb = {b_pc, b_ifid, b_idex, b_exmem, b_memwb, b_fl, b_bb};
   assign pc = {c_pc, c_ifid, c_idex, c_exmem, c_memwb, c_fl, c_bb};

   pipeline_stall_controller #(.BR_LD_STALLS(2), .CNT_W(16)) u_a (
      .i_clk(clk), .i_rst(rst), .i_load_use(lu), .i_br_stall(bs),
      .i_br_ld_stall(bl), .i_br_taken(bt), .i_mem_busy(mb),
      .o_pc_en(a_pc), .o_if_id_en(a_ifid), .o_id_ex_en(a_idex),
      .o_ex_mem_en(a_exmem), .o_mem_wb_en(a_memwb), .o_if_id_flush(a_fl),
      .o_id_ex_bubble(a_bb), .o_stall_cnt(a_scnt), .o_flush_cnt(a_fcnt));

   pipeline_stall_controller #(.BR_LD_STALLS(3), .CNT_W(16)) u_b (
      .i_clk(clk), .i_rst(rst), .i_load_use(lu), .i_br_stall(bs),
      .i_br_ld_stall(bl), .i_br_taken(bt), .i_mem_busy(mb),
      .o_pc_en(b_pc), .o_if_id_en(b_ifid), .o_id_ex_en(b_idex),
      .o_ex_mem_en(b_exmem), .o_mem_wb_en(b_memwb), .o_if_id_flush(b_fl),
      .o_id_ex_bubble(b_bb), .o_stall_cnt(b_scnt), .o_flush_cnt(b_fcnt));

   pipeline_stall_controller #(.BR_LD_STALLS(1), .CNT_W(2)) u_c (
      .i_clk(clk), .i_rst(rst), .i_load_use(lu), .i_br_stall(bs),
      .i_br_ld_stall(bl), .i_br_taken(bt), .i_mem_busy(mb),
      .o_pc_en(c_pc), .o_if_id_en(c_ifid), .o_id_ex_en(c_idex),
      .o_ex_mem_en(c_exmem), .o_mem_wb_en(c_memwb), .o_if_id_flush(c_fl),
      .o_id_ex_bubble(c_bb), .o_stall_cnt(c_scnt), .o_flush_cnt(c_fcnt));

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Drive one cycle's inputs after the falling edge; outputs settle 1 ns later
   task automatic step(input logic r, input logic l, input logic s,
                       input logic d, input logic t, input logic m);
      @(negedge clk);
      rst = r; lu = l; bs = s; bl = d; bt = t; mb = m;
      #1;
   endtask

   task automatic do_reset();
      step(1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
   endtask

   initial begin
      // Reset with memory busy
      step(1, 0, 0, 0, 0, 1);
      chk("rst_pat_a", 32'(pa), 32'(P_RST));
      step(1, 0, 0, 0, 0, 1);
      chk("rst_pat_b", 32'(pb), 32'(P_RST));
      chk("rst_scnt", 32'(a_scnt), 0);
      chk("rst_fcnt", 32'(a_fcnt), 0);
      step(0, 0, 0, 0, 0, 0);
      chk("post_rst_run", 32'(pa), 32'(P_RUN));
      chk("post_rst_scnt", 32'(a_scnt), 0);

      // Load-use single stall
      step(0, 1, 0, 0, 0, 0);
      chk("lu_stall", 32'(pa), 32'(P_STALL));
      step(0, 0, 0, 0, 0, 0);
      chk("lu_after", 32'(pa), 32'(P_RUN));
      chk("lu_scnt", 32'(a_scnt), 1);

      // Branch-on-ALU single stall
      step(0, 0, 1, 0, 0, 0);
      chk("bs_stall", 32'(pa), 32'(P_STALL));
      step(0, 0, 0, 0, 0, 0);
      chk("bs_after", 32'(pa), 32'(P_RUN));
      chk("bs_scnt", 32'(a_scnt), 2);

      // Branch-on-load: 2, 3 and 1 stall cycles
      do_reset();
      step(0, 0, 0, 1, 0, 0);
      chk("bl_c1_a", 32'(pa), 32'(P_STALL));
      chk("bl_c1_b", 32'(pb), 32'(P_STALL));
      chk("bl_c1_c", 32'(pc), 32'(P_STALL));
      step(0, 0, 0, 0, 0, 0);
      chk("bl_c2_a", 32'(pa), 32'(P_STALL));
      chk("bl_c2_b", 32'(pb), 32'(P_STALL));
      chk("bl_c2_c", 32'(pc), 32'(P_RUN));
      step(0, 0, 0, 0, 0, 0);
      chk("bl_c3_a", 32'(pa), 32'(P_RUN));
      chk("bl_c3_b", 32'(pb), 32'(P_STALL));
      chk("bl_a_scnt", 32'(a_scnt), 2);
      step(0, 0, 0, 0, 0, 0);
      chk("bl_c4_b", 32'(pb), 32'(P_RUN));
      chk("bl_b_scnt", 32'(b_scnt), 3);
      chk("bl_c_scnt", 32'(c_scnt), 1);

      // Memory freeze with load-use and taken branch pending
      do_reset();
      step(0, 1, 0, 0, 1, 1);
      chk("mw_f1", 32'(pa), 32'(P_FREEZE));
      step(0, 1, 0, 0, 0, 1);
      chk("mw_f2", 32'(pa), 32'(P_FREEZE));
      step(0, 1, 0, 0, 0, 1);
      chk("mw_f3", 32'(pa), 32'(P_FREEZE));
      step(0, 1, 0, 0, 0, 1);
      chk("mw_f4", 32'(pa), 32'(P_FREEZE));
      step(0, 1, 0, 0, 0, 0);
      chk("mw_lu", 32'(pa), 32'(P_STALL));
      step(0, 0, 0, 0, 0, 0);
      chk("mw_run", 32'(pa), 32'(P_RUN));
      chk("mw_scnt", 32'(a_scnt), 5);
      chk("mw_fcnt", 32'(a_fcnt), 0);

      // Freeze interrupting HOLD (BR_LD_STALLS=3); taken branch ignored in HOLD
      do_reset();
      step(0, 0, 0, 1, 0, 0);
      chk("mh_s1", 32'(pb), 32'(P_STALL));
      step(0, 0, 0, 0, 1, 0);
      chk("mh_s2", 32'(pb), 32'(P_STALL));
      step(0, 0, 0, 0, 0, 1);
      chk("mh_f1", 32'(pb), 32'(P_FREEZE));
      step(0, 0, 0, 0, 0, 1);
      chk("mh_f2", 32'(pb), 32'(P_FREEZE));
      step(0, 0, 0, 0, 0, 0);
      chk("mh_s3", 32'(pb), 32'(P_STALL));
      step(0, 0, 0, 0, 0, 0);
      chk("mh_run", 32'(pb), 32'(P_RUN));
      chk("mh_scnt", 32'(b_scnt), 5);
      chk("mh_fcnt", 32'(b_fcnt), 0);

      // Reset arriving mid-stall
      step(0, 0, 0, 1, 0, 0);
      chk("rm_stall", 32'(pb), 32'(P_STALL));
      step(1, 0, 0, 0, 0, 0);
      chk("rm_rst", 32'(pb), 32'(P_RST));
      step(0, 0, 0, 0, 0, 0);
      chk("rm_run", 32'(pb), 32'(P_RUN));
      chk("rm_scnt", 32'(b_scnt), 0);

      // Taken branch vs load-use, then a real flush
      do_reset();
      step(0, 1, 0, 0, 1, 0);
      chk("bt_lu", 32'(pa), 32'(P_STALL));
      step(0, 0, 0, 0, 0, 0);
      chk("bt_lu_fcnt", 32'(a_fcnt), 0);
      step(0, 0, 0, 0, 1, 0);
      chk("bt_flush", 32'(pa), 32'(P_FLUSH));
      step(0, 0, 0, 0, 0, 0);
      chk("bt_run", 32'(pa), 32'(P_RUN));
      chk("bt_fcnt", 32'(a_fcnt), 1);
      chk("bt_scnt", 32'(a_scnt), 1);

      // Saturation of 2-bit counters
      do_reset();
      for (int i = 0; i < 5; i++) begin
         step(0, 0, 0, 0, 1, 0);
         chk($sformatf("sat_flush%0d", i), 32'(pc), 32'(P_FLUSH));
      end
      step(0, 0, 0, 0, 0, 0);
      chk("sat_fcnt_c", 32'(c_fcnt), 3);
      chk("sat_fcnt_a", 32'(a_fcnt), 5);
      for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      chk("sat_scnt_c", 32'(c_scnt), 3);
      chk("sat_scnt_a", 32'(a_scnt), 5);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
